// File: rtl/sdram_pkg.sv
// sdram_pkg: shared command/state types, error codes and command decode for sdram_responder
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_DESEL,
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE
    } cmd_t;

    typedef enum logic [2:0] {PWRUP, PRE_DONE, REF1, REF2, READY} init_state_t;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_NOT_INIT    = 3'd1;
    localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
    localparam logic [2:0] ERR_TRCD        = 3'd3;
    localparam logic [2:0] ERR_ACT_OPEN    = 3'd4;
    localparam logic [2:0] ERR_REF_OPEN    = 3'd5;
    localparam logic [2:0] ERR_BAD_MODE    = 3'd6;

    // BURST_TERM (0110) falls through to NOP
    function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n, input logic cas_n,
                                        input logic we_n);
        logic [2:0] c;
        c = {ras_n, cas_n, we_n};
        return cs_n        ? CMD_DESEL :
               c == 3'b011 ? CMD_ACTIVE :
               c == 3'b101 ? CMD_READ :
               c == 3'b100 ? CMD_WRITE :
               c == 3'b010 ? CMD_PRECHARGE :
               c == 3'b001 ? CMD_REFRESH :
               c == 3'b000 ? CMD_LOAD_MODE : CMD_NOP;
    endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// sdram_read_pipe: CAS-latency read return pipe
//   hclk/rst   clock, async active-high reset (flushes all entries)
//   en         clock enable; 0 holds every stage and the output
//   push       a legal READ was taken this edge; push_data/push_cl are its word and latency
//   dq_o/dq_oe returned word and its one-cycle valid
module sdram_read_pipe #(
    parameter int DATA_W = 16
) (
    input  logic              hclk,
    input  logic              rst,
    input  logic              en,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [2:0]        push_cl,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe
);
    logic [2:0]             vld_q, vld_d;
    logic [2:0]             cl3_q, cl3_d;
    logic [2:0][DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0]      dq_o_q, dq_o_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   sel1, sel2;

    // Stage k holds an entry k edges after its READ; the registered output
    // therefore takes stage CL-1 so it appears exactly CL edges after the READ.
    always_comb begin
        vld_d   = en ? {vld_q[1:0], push} : vld_q;
        cl3_d   = en ? {cl3_q[1:0], push_cl == 3'd3} : cl3_q;
        dat_d   = en ? {dat_q[1:0], push_data} : dat_q;
        sel2    = vld_q[2] && cl3_q[2];
        sel1    = vld_q[1] && !cl3_q[1];
        dq_oe_d = en ? (sel2 || sel1) : dq_oe_q;
        dq_o_d  = en ? (sel2 ? dat_q[2] : sel1 ? dat_q[1] : '0) : dq_o_q;
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            cl3_q   <= '0;
            dat_q   <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            cl3_q   <= cl3_d;
            dat_q   <= dat_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign dq_o  = dq_o_q;
    assign dq_oe = dq_oe_q;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDRAM model checking init, tRCD and bank state
//   hclk/rst                   clock, async active-high reset
//   mem_cke..mem_addr          controller command bus (sampled only when mem_cke=1)
//   mem_dq_i                   write data taken with WRITE
//   mem_dq_o/mem_dq_oe         read data, valid CL cycles after READ
//   init_done/bank_open        init complete, per-bank open flags
//   cmd_err/err_code           one-cycle error pulse and sticky cause
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 4,
    parameter int T_RCD  = 2
) (
    input  logic              hclk,
    input  logic              rst,
    input  logic              mem_cke,
    input  logic              mem_CSn,
    input  logic              mem_RASn,
    input  logic              mem_CASn,
    input  logic              mem_WEn,
    input  logic [1:0]        mem_ba,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dq_i,
    output logic [DATA_W-1:0] mem_dq_o,
    output logic              mem_dq_oe,
    output logic              init_done,
    output logic [3:0]        bank_open,
    output logic              cmd_err,
    output logic [2:0]        err_code
);
    localparam int IDX_W = 2 + ROW_W + COL_W;
    localparam int RCD_W = $clog2(T_RCD + 1);

    init_state_t           state_q, state_d;
    logic [2:0]            cl_q, cl_d;
    logic [3:0]            open_q, open_d;
    logic [3:0][ROW_W-1:0] row_q, row_d;
    logic [3:0][RCD_W-1:0] rcd_q, rcd_d;
    logic                  err_q;
    logic [2:0]            code_q, code_d, err_d;
    logic                  wr_en, rd_en, ready, mode_ok;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     mem_q [2**IDX_W];
    cmd_t                  cmd;
    logic                  unused_addr;

    assign unused_addr = ^mem_addr;

    always_comb begin
        cmd     = mem_cke ? decode_cmd(mem_CSn, mem_RASn, mem_CASn, mem_WEn) : CMD_NOP;
        idx     = {mem_ba, row_q[mem_ba], mem_addr[COL_W-1:0]};
        ready   = state_q == READY;
        mode_ok = mem_addr[2:0] == 3'b000 && (mem_addr[6:4] == 3'd2 || mem_addr[6:4] == 3'd3);
        state_d = state_q;
        cl_d    = cl_q;
        open_d  = open_q;
        row_d   = row_q;
        err_d   = ERR_NONE;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        for (int b = 0; b < 4; b++)
            rcd_d[b] = (mem_cke && rcd_q[b] != '0) ? rcd_q[b] - 1'b1 : rcd_q[b];
        case (cmd)
            CMD_PRECHARGE:
                if (ready) open_d = mem_addr[10] ? 4'b0000 : open_q & ~(4'b0001 << mem_ba);
                else if (state_q == PWRUP && mem_addr[10]) state_d = PRE_DONE;
                else err_d = ERR_NOT_INIT;
            CMD_REFRESH:
                if (state_q == PRE_DONE) state_d = REF1;
                else if (state_q == REF1) state_d = REF2;
                else if (ready) err_d = |open_q ? ERR_REF_OPEN : ERR_NONE;
                else err_d = ERR_NOT_INIT;
            CMD_LOAD_MODE:
                if (!(ready || state_q == REF2)) err_d = ERR_NOT_INIT;
                else if (!mode_ok) err_d = ERR_BAD_MODE;
                else begin
                    cl_d    = mem_addr[6:4];
                    state_d = READY;
                end
            CMD_ACTIVE:
                if (!ready) err_d = ERR_NOT_INIT;
                else if (open_q[mem_ba]) err_d = ERR_ACT_OPEN;
                else begin
                    open_d[mem_ba] = 1'b1;
                    row_d[mem_ba]  = mem_addr[ROW_W-1:0];
                    rcd_d[mem_ba]  = RCD_W'(T_RCD - 1);
                end
            CMD_READ, CMD_WRITE:
                if (!ready) err_d = ERR_NOT_INIT;
                else if (!open_q[mem_ba]) err_d = ERR_BANK_CLOSED;
                else if (rcd_q[mem_ba] != '0) err_d = ERR_TRCD;
                else begin
                    wr_en = cmd == CMD_WRITE;
                    rd_en = cmd == CMD_READ;
                    if (mem_addr[10]) open_d[mem_ba] = 1'b0;
                end
            default: ;
        endcase
        code_d = err_d != ERR_NONE ? err_d : code_q;
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            state_q <= PWRUP;
            cl_q    <= 3'd2;
            open_q  <= '0;
            row_q   <= '0;
            rcd_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cl_q    <= cl_d;
            open_q  <= open_d;
            row_q   <= row_d;
            rcd_q   <= rcd_d;
            err_q   <= err_d != ERR_NONE;
            code_q  <= code_d;
        end
    end

    // Storage is deliberately unreset so data survives a controller reset
    always_ff @(posedge hclk) begin
        if (wr_en) mem_q[idx] <= mem_dq_i;
    end

    // Array read happens at the READ edge, so later writes cannot alter in-flight data
    sdram_read_pipe #(.DATA_W(DATA_W)) u_pipe (
        .hclk      (hclk),
        .rst       (rst),
        .en        (mem_cke),
        .push      (rd_en),
        .push_data (mem_q[idx]),
        .push_cl   (cl_q),
        .dq_o      (mem_dq_o),
        .dq_oe     (mem_dq_oe)
    );

    assign init_done = state_q == READY;
    assign bank_open = open_q;
    assign cmd_err   = err_q;
    assign err_code  = code_q;

endmodule
